spi_slave_rx_frontend: RTL and testbench

Upstream front-end of the SPI slave receive path. Synchronises the raw asynchronous SPI pins (sclk, mosi, cs) into the system clock domain and detects the sampling edge. It produces the cs / sample / in triple consumed by the odd-parity FSM, and also assembles MSB-first bytes with a valid strobe and a frame-error flag for the byte-level consumer.

---
 rtl/spi_slave_rx_frontend.sv | 140 ++++++++++++++
 tb/tb_spi_slave_rx_frontend.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_frontend.sv
// SPI slave receive front-end: synchronises raw SPI pins, detects the sampling edge and
// assembles MSB-first words with a valid strobe and a mid-word chip-select error flag.
module spi_slave_rx_frontend #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sclk_raw,
  input  logic                      mosi_raw,
  input  logic                      cs_raw,
  output logic                      cs,
  output logic                      sample,
  output logic                      in,
  output logic [DATA_W-1:0]         rx_byte,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic [$clog2(DATA_W):0]   bit_cnt
);

  localparam int unsigned CntW         = $clog2(DATA_W) + 1;
  localparam logic        IdleLvl      = (CPOL != 0);
  localparam logic [2:0]  ResyncCycles = 3'(SYNC_STAGES + 1);

  localparam logic [1:0] StResync = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StShift  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, mosi_s, cs_s, edge_det, word_done;

  logic [1:0]        state_q, state_d;
  logic [2:0]        rs_cnt_q, rs_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              cs_q, cs_d;
  logic              sample_q, sample_d;
  logic              in_q, in_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign edge_det  = IdleLvl ? (~sclk_s & sclk_dly_q) : (sclk_s & ~sclk_dly_q);
  assign word_done = (bit_cnt_q == CntW'(DATA_W));

  always_comb begin
    state_d     = state_q;
    rs_cnt_d    = rs_cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    sample_d    = 1'b0;
    in_d        = in_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StResync: begin
        bit_cnt_d = '0;
        // Wait out the synchroniser fill, then for any frame in flight at reset to end.
        if (rs_cnt_q != ResyncCycles) begin
          rs_cnt_d = rs_cnt_q + 3'd1;
        end else if (cs_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        bit_cnt_d = '0;
        if (!cs_s) state_d = StShift;
      end
      StShift: begin
        if (word_done) begin
          rx_byte_d  = shift_q;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
        end
        // Deselect beats a coincident sampling edge; a just-completed word still counts.
        if (cs_s) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          if (!word_done && (bit_cnt_q != '0)) frame_err_d = 1'b1;
        end else if (edge_det) begin
          sample_d  = 1'b1;
          in_d      = mosi_s;
          shift_d   = {shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = (word_done ? '0 : bit_cnt_q) + CntW'(1);
        end
      end
      default: state_d = StResync;
    endcase
    cs_d = (state_d != StShift);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{IdleLvl}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= IdleLvl;
      state_q     <= StResync;
      rs_cnt_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cs_q        <= 1'b1;
      sample_q    <= 1'b0;
      in_q        <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_raw};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_raw};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_raw};
      sclk_dly_q  <= sclk_s;
      state_q     <= state_d;
      rs_cnt_q    <= rs_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cs_q        <= cs_d;
      sample_q    <= sample_d;
      in_q        <= in_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cs        = cs_q;
  assign sample    = sample_q;
  assign in        = in_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx_frontend.sv
// Bench for spi_slave_rx_frontend: a CPOL=0 and a CPOL=1 instance see the same frames
// (the second gets inverted sclk) and are scored against frame-level expectations.
module tb_spi_slave_rx_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sclk_raw, mosi_raw, cs_raw, sclk_inv;
  assign sclk_inv = ~sclk_raw;

  logic [1:0] cs_o, samp, in_b, rxv, ferr;
  logic [7:0] rxb [2];
  logic [3:0] bc [2];

  spi_slave_rx_frontend #(.DATA_W(8), .CPOL(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .sclk_raw(sclk_raw), .mosi_raw(mosi_raw), .cs_raw(cs_raw),
    .cs(cs_o[0]), .sample(samp[0]), .in(in_b[0]), .rx_byte(rxb[0]), .rx_valid(rxv[0]),
    .frame_err(ferr[0]), .bit_cnt(bc[0])
  );

  spi_slave_rx_frontend #(.DATA_W(8), .CPOL(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .sclk_raw(sclk_inv), .mosi_raw(mosi_raw), .cs_raw(cs_raw),
    .cs(cs_o[1]), .sample(samp[1]), .in(in_b[1]), .rx_byte(rxb[1]), .rx_valid(rxv[1]),
    .frame_err(ferr[1]), .bit_cnt(bc[1])
  );

  // Monotonic event counters and shift logs, sampled on the falling clock edge.
  int          sn[2] = '{0, 0}, nv[2] = '{0, 0}, nf[2] = '{0, 0}, dbl[2] = '{0, 0};
  int          cslow[2] = '{0, 0}, bcbad[2] = '{0, 0}, bc8[2] = '{0, 0};
  logic [63:0] sbits[2] = '{64'd0, 64'd0}, rxlog[2] = '{64'd0, 64'd0};
  logic [1:0]  samp_prev = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (samp[i]) begin
        sn[i]    <= sn[i] + 1;
        sbits[i] <= {sbits[i][62:0], in_b[i]};
        if (samp_prev[i]) dbl[i] <= dbl[i] + 1;
      end
      if (rxv[i]) begin
        nv[i]    <= nv[i] + 1;
        rxlog[i] <= {rxlog[i][55:0], rxb[i]};
      end
      if (ferr[i]) nf[i] <= nf[i] + 1;
      if (!cs_o[i]) cslow[i] <= cslow[i] + 1;
      if (bc[i] > 4'd8 || (rxv[i] && bc[i] != 4'd0)) bcbad[i] <= bcbad[i] + 1;
      if (bc[i] == 4'd8) bc8[i] <= bc8[i] + 1;
    end
    samp_prev <= samp;
  end

  int         b_sn[2], b_nv[2], b_nf[2], b_dbl[2], b_cslow[2], b_bcbad[2], b_bc8[2];
  logic [7:0] exp_rx[2] = '{8'h00, 8'h00};
  int         n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_sn[i] = sn[i]; b_nv[i] = nv[i]; b_nf[i] = nf[i]; b_dbl[i] = dbl[i];
      b_cslow[i] = cslow[i]; b_bcbad[i] = bcbad[i]; b_bc8[i] = bc8[i];
    end
  endtask

  // Frame-level expectations: n bits received, n/8 whole words, error iff a partial word.
  task automatic score(input logic [63:0] bits, input int n);
    int          nw;
    logic [63:0] m, wm, words;
    nw    = n / 8;
    m     = (64'd1 << n) - 64'd1;
    wm    = (64'd1 << (nw * 8)) - 64'd1;
    words = ((bits & m) >> (n % 8)) & wm;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("samples%0d", i), 64'(sn[i] - b_sn[i]), 64'(n));
      check($sformatf("in_seq%0d", i), sbits[i] & m, bits & m);
      check($sformatf("rx_valid_cnt%0d", i), 64'(nv[i] - b_nv[i]), 64'(nw));
      check($sformatf("rx_words%0d", i), rxlog[i] & wm, words);
      if (nw > 0) exp_rx[i] = words[7:0];
      check($sformatf("rx_byte%0d", i), 64'(rxb[i]), 64'(exp_rx[i]));
      check($sformatf("frame_err_cnt%0d", i), 64'(nf[i] - b_nf[i]), 64'((n % 8) != 0));
      check($sformatf("double_sample%0d", i), 64'(dbl[i] - b_dbl[i]), 64'd0);
      check($sformatf("bit_cnt_bad%0d", i), 64'(bcbad[i] - b_bcbad[i]), 64'd0);
      check($sformatf("bit_cnt_full%0d", i), 64'(bc8[i] - b_bc8[i]), 64'(nw));
      check($sformatf("cs_end%0d", i), 64'(cs_o[i]), 64'd1);
      check($sformatf("bit_cnt_end%0d", i), 64'(bc[i]), 64'd0);
    end
  endtask

  task automatic send_bit(input logic b, input int h, input bit cut_here, input bit meas);
    mosi_raw = b;
    repeat (h) @(negedge clk);
    if (cut_here) cs_raw = 1'b1;
    sclk_raw = 1'b1;
    if (meas) begin
      int k;
      k = 0;
      while (!samp[0] && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("latency", 64'(k), 64'd3);
      if (h > k) repeat (h - k) @(negedge clk);
    end else begin
      repeat (h) @(negedge clk);
    end
    sclk_raw = 1'b0;
  endtask

  // Sends n bits MSB first; with cut, cs_raw rises together with the last sclk edge.
  task automatic run_frame(input logic [63:0] bits, input int n, input int h, input bit cut,
                           input bit meas);
    snap();
    cs_raw = 1'b0;
    repeat (6) @(negedge clk);
    for (int j = 0; j < n; j++) send_bit(bits[n-1-j], h, cut && (j == n - 1), meas && (j == 0));
    repeat (h) @(negedge clk);
    cs_raw = 1'b1;
    repeat (8) @(negedge clk);
    if (cut) score(bits >> 1, n - 1);
    else score(bits, n);
  endtask

  initial begin
    reset = 1'b1; sclk_raw = 1'b0; mosi_raw = 1'b0; cs_raw = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_cs%0d", i), 64'(cs_o[i]), 64'd1);
      check($sformatf("rst_sample%0d", i), 64'(samp[i]), 64'd0);
      check($sformatf("rst_in%0d", i), 64'(in_b[i]), 64'd0);
      check($sformatf("rst_rx_byte%0d", i), 64'(rxb[i]), 64'd0);
      check($sformatf("rst_rx_valid%0d", i), 64'(rxv[i]), 64'd0);
      check($sformatf("rst_frame_err%0d", i), 64'(ferr[i]), 64'd0);
      check($sformatf("rst_bit_cnt%0d", i), 64'(bc[i]), 64'd0);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);

    run_frame(64'hA5, 8, 4, 1'b0, 1'b1);
    run_frame(64'h3CFF, 16, 4, 1'b0, 1'b0);
    run_frame(64'h10, 5, 4, 1'b0, 1'b0);

    // Reset in the middle of a frame; master keeps clocking while selected.
    cs_raw = 1'b0;
    repeat (6) @(negedge clk);
    for (int j = 0; j < 3; j++) send_bit(1'($urandom), 4, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap();
    for (int i = 0; i < 2; i++) begin
      exp_rx[i] = 8'h00;
      check($sformatf("midrst_rx_byte%0d", i), 64'(rxb[i]), 64'd0);
    end
    for (int j = 0; j < 3; j++) send_bit(1'($urandom), 4, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrst_samples%0d", i), 64'(sn[i] - b_sn[i]), 64'd0);
      check($sformatf("midrst_cs_low%0d", i), 64'(cslow[i] - b_cslow[i]), 64'd0);
      check($sformatf("midrst_frame_err%0d", i), 64'(nf[i] - b_nf[i]), 64'd0);
    end
    cs_raw = 1'b1;
    repeat (8) @(negedge clk);
    run_frame(64'h01, 8, 4, 1'b0, 1'b0);

    run_frame(64'hC3, 8, 4, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int          n, h;
      logic [63:0] bits;
      n    = int'($urandom_range(1, 40));
      h    = int'($urandom_range(3, 6));
      bits = {32'($urandom), 32'($urandom)} & ((64'd1 << n) - 64'd1);
      run_frame(bits, n, h, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
